// File: rtl/step_pkg.sv
// Shared definitions for the step decoder: sequencer state encoding and default index width.
package step_pkg;

    localparam int DEF_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } step_state_t;

endpackage

// File: rtl/onehot_enc.sv
// Combinational index-to-one-hot converter used by the step decoder.
module onehot_enc
    import step_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/step_decoder.sv
// Step sequencer with registered one-hot decode; wraps or halts at LAST_STEP.
// Define STEP_DECODER_ERR_EN to add the err pulse output for ignored loads/steps.
module step_decoder
    import step_pkg::*;
#(
    parameter int SEL_W     = DEF_SEL_W,
    parameter int LAST_STEP = (2**SEL_W) - 1,
    parameter int WRAP      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  step,
    output logic [2**SEL_W-1:0]   onehot,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  last
`ifdef STEP_DECODER_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int              OUT_N    = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST_STEP);

    step_state_t      state;
    logic             load_ok;
    logic             at_last;
    logic [SEL_W-1:0] adv_idx;
    logic [SEL_W-1:0] enc_idx;
    logic [OUT_N-1:0] enc_onehot;

    // One encoder serves both a legal load and an advance; load wins the mux, matching the priority order.
    always_comb begin
        load_ok = load && (sel <= LAST_IDX);
        at_last = (idx == LAST_IDX);
        adv_idx = at_last ? '0 : idx + SEL_W'(1);
        enc_idx = load_ok ? sel : adv_idx;
    end

    onehot_enc #(
        .SEL_W (SEL_W)
    ) u_enc (
        .sel    (enc_idx),
        .onehot (enc_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            onehot <= '0;
            valid  <= 1'b0;
            last   <= 1'b0;
`ifdef STEP_DECODER_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
`ifdef STEP_DECODER_ERR_EN
            err <= 1'b0;
`endif
            if (clr) begin
                state  <= IDLE;
                idx    <= '0;
                onehot <= '0;
                valid  <= 1'b0;
                last   <= 1'b0;
            end else if (load) begin
                // An out-of-range load still consumes the cycle, so a simultaneous step is dropped.
                if (load_ok) begin
                    state  <= RUN;
                    idx    <= sel;
                    onehot <= enc_onehot;
                    valid  <= 1'b1;
                    last   <= (sel == LAST_IDX);
                end else begin
`ifdef STEP_DECODER_ERR_EN
                    err <= 1'b1;
`endif
                end
            end else if (step) begin
                case (state)
                    RUN: begin
                        if (at_last && (WRAP == 0)) begin
                            state <= HALT;
                        end else begin
                            idx    <= adv_idx;
                            onehot <= enc_onehot;
                            last   <= (adv_idx == LAST_IDX);
                        end
                    end
                    HALT: begin
`ifdef STEP_DECODER_ERR_EN
                        err <= 1'b1;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
